ir_sort_ctrl: RTL and testbench
===============================

# ir_sort_ctrl

Downstream consumer of the IR sensor's `iFlag` classification. Samples the 2-bit code once per sensor window and requires `VOTE_N` consecutive identical valid codes before acting. Then drives a sorting-gate servo to the class position, holds it, returns it to centre, and reports completion. Sits between the IR sensor stage and the gate servo pin.

## Interface
Parameters:
- `SAMPLE_PERIOD`, 30_000_000: cycles between `iFlag` samples; matches the sensor window.
- `VOTE_N`, 3: consecutive identical valid samples required, range 1..15.
- `HOLD_CYCLES`, 100_000_000: cycles in each of ACTUATE and RETURN.
- `PWM_PERIOD`, 2_000_000: servo frame length in cycles (20 ms).
- `PW_CENTER`, 150_000; `PW_A`, 100_000; `PW_B`, 200_000: servo high time in cycles for centre, class A and class B. Each must be less than `PWM_PERIOD`.

Ports:
- `CLK100MHZ` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `iFlag` in 2: sensor classification. 2'b10 is class A, 2'b01 is class B, 2'b00 and 2'b11 are invalid.
- `servo_pwm` out 1: servo control pulse, registered.
- `busy` out 1: high in ACTUATE and RETURN.
- `sort_class` out 2: class of the current or most recent sort; 2'b00 until the first sort.
- `sort_done` out 1: one-cycle pulse on the RETURN→IDLE transition.
- `cnt_a`, `cnt_b` out 8: sorted-item counters (see Configuration).

## Operation
- Sample counter `scnt` runs 0..SAMPLE_PERIOD-1 and wraps. `tick` is asserted on the cycle where `scnt == SAMPLE_PERIOD-1`. The counter is free-running in every state.
- Vote state: `last` (2 bits) and `streak` (4 bits).
- On a `tick` in IDLE:
  - If `iFlag` is invalid: `streak <= 0`.
  - Else if `iFlag == last` and `streak != 0`: `streak <= streak+1`.
  - Else: `streak <= 1`.
  - In every case, `last <= iFlag`.
- Trigger condition: the value being written to `streak` equals `VOTE_N`. Then on that same edge:
  - go to ACTUATE;
  - `sort_class <= iFlag`;
  - `streak <= 0`;
  - increment the class counter.
- States:
  - IDLE: servo target is `PW_CENTER`.
  - ACTUATE: target is `PW_A` or `PW_B` per `sort_class`. Lasts `HOLD_CYCLES` cycles, then RETURN.
  - RETURN: target is `PW_CENTER`. Lasts `HOLD_CYCLES` cycles, then IDLE with `sort_done` = 1 for one cycle.
- Ticks in ACTUATE or RETURN are ignored; `streak` stays 0. Voting restarts fresh in IDLE.
- PWM:
  - Frame counter `fcnt` runs 0..PWM_PERIOD-1.
  - `pw_active` loads the current target only when `fcnt == PWM_PERIOD-1`, so the pulse width never changes mid-frame.
  - `servo_pwm <= (fcnt < pw_active)`.
- Counters saturate at 255; no wrap.
- Reset (when `rst_n` = 0 at an edge) returns the block to IDLE from any state, including mid-ACTUATE. Reset values:
  - `scnt`, `fcnt`, `streak`, `last`: 0.
  - `pw_active`: `PW_CENTER`.
  - `servo_pwm`, `busy`, `sort_done`: 0.
  - `sort_class`: 2'b00; `cnt_a`, `cnt_b`: 0.

## Timing
- First `tick` occurs `SAMPLE_PERIOD` cycles after reset release.
- Decision latency: `busy` rises on the edge of the VOTE_N-th qualifying tick, i.e. zero cycles after the tick cycle.
- `busy` is high for exactly 2×`HOLD_CYCLES` cycles. `sort_done` pulses on the first cycle in IDLE; `busy` is 0 in that cycle.
- A new target reaches `servo_pwm` at the start of the next frame. `servo_pwm` lags `fcnt` by one cycle.
- First `servo_pwm` high cycle after reset: cycle 1. The pulse is `PW_CENTER` cycles wide.
- A `tick` coinciding with RETURN→IDLE is ignored, because the state is still RETURN on that edge.

## Configuration
- `IR_SORT_COUNT_EN` defined: `cnt_a` and `cnt_b` are live saturating counters.
- `IR_SORT_COUNT_EN` undefined: no counter registers are built; `cnt_a` and `cnt_b` are tied to 8'd0. All other behaviour is identical.

## Test plan
Parameters for all scenarios: SAMPLE_PERIOD=10, VOTE_N=3, HOLD_CYCLES=50, PWM_PERIOD=20, PW_CENTER=5, PW_A=2, PW_B=8.
- Reset release with `iFlag`=2'b00 held for 200 cycles → no `busy`; `servo_pwm` high 5 of every 20 cycles; all counters 0.
- `iFlag`=2'b10 held → `busy` rises on the 3rd tick edge (cycle 30 after release) and `sort_class`=2'b10. The next frame shows 2-cycle pulses. `sort_done` pulses 100 cycles later. `cnt_a`=1.
- `iFlag` sequence 10,10,01,01,01 across ticks → trigger on the 5th tick with class B (8-cycle pulses); `cnt_b`=1, `cnt_a`=0.
- Sequence 10,11,10,10 → invalid code resets the streak; no trigger until the 3rd consecutive 10 after the 11, i.e. never within these 4 ticks.
- `rst_n` low for 1 cycle mid-ACTUATE → `busy`=0 and `sort_class`=00 next cycle; centre pulses resume; counters return to 0.
- 300 back-to-back class-A sorts → `cnt_a` saturates at 255. With `IR_SORT_COUNT_EN` undefined, `cnt_a` stays 0.

Source files
------------

// File: rtl/ir_sort_ctrl.sv
// ir_sort_ctrl: IR class vote -> sorting-gate servo sequencer; IR_SORT_COUNT_EN enables the item counters.
module ir_sort_ctrl #(
    parameter int SAMPLE_PERIOD = 30_000_000,
    parameter int VOTE_N        = 3,
    parameter int HOLD_CYCLES   = 100_000_000,
    parameter int PWM_PERIOD    = 2_000_000,
    parameter int PW_CENTER     = 150_000,
    parameter int PW_A          = 100_000,
    parameter int PW_B          = 200_000
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic [1:0] iFlag,
    output logic       servo_pwm,
    output logic       busy,
    output logic [1:0] sort_class,
    output logic       sort_done,
    output logic [7:0] cnt_a,
    output logic [7:0] cnt_b
);
    localparam int SW = $clog2(SAMPLE_PERIOD + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int FW = $clog2(PWM_PERIOD + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACT, S_RET} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] scnt;
    logic [HW-1:0] hcnt;
    logic [FW-1:0] fcnt, pw_active, target;
    logic [3:0]    streak, streak_nx;
    logic [1:0]    last;
    logic          tick, valid, trig, hold_end, frame_end;

    assign tick      = scnt == SW'(SAMPLE_PERIOD - 1);
    assign hold_end  = hcnt == HW'(HOLD_CYCLES - 1);
    assign frame_end = fcnt == FW'(PWM_PERIOD - 1);
    assign valid     = iFlag[1] ^ iFlag[0];
    assign busy      = state != S_IDLE;

    always_comb begin
        streak_nx = !valid ? 4'd0 : (iFlag == last && streak != 4'd0) ? streak + 4'd1 : 4'd1;
        trig      = state == S_IDLE && tick && streak_nx == 4'(VOTE_N);
        state_nx  = trig ? S_ACT :
                    (state == S_ACT && hold_end) ? S_RET :
                    (state == S_RET && hold_end) ? S_IDLE : state;
        target    = state == S_ACT ? (sort_class == 2'b10 ? FW'(PW_A) : FW'(PW_B)) : FW'(PW_CENTER);
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            scnt       <= '0;
            fcnt       <= '0;
            hcnt       <= '0;
            streak     <= '0;
            last       <= '0;
            pw_active  <= FW'(PW_CENTER);
            servo_pwm  <= 1'b0;
            sort_class <= 2'b00;
            sort_done  <= 1'b0;
        end else begin
            scnt      <= tick ? '0 : scnt + 1'b1;
            fcnt      <= frame_end ? '0 : fcnt + 1'b1;
            hcnt      <= (state == S_IDLE || hold_end) ? '0 : hcnt + 1'b1;
            sort_done <= state == S_RET && hold_end;
            servo_pwm <= fcnt < pw_active;
            // width only changes at a frame boundary so no pulse is ever truncated
            if (frame_end) pw_active <= target;
            if (state == S_IDLE && tick) begin
                streak <= trig ? 4'd0 : streak_nx;
                last   <= iFlag;
            end
            if (trig) sort_class <= iFlag;
        end
    end

`ifdef IR_SORT_COUNT_EN
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (trig) begin
            if (iFlag == 2'b10 && cnt_a != 8'hFF) cnt_a <= cnt_a + 1'b1;
            if (iFlag == 2'b01 && cnt_b != 8'hFF) cnt_b <= cnt_b + 1'b1;
        end
    end
`else
    assign cnt_a = 8'd0;
    assign cnt_b = 8'd0;
`endif
endmodule

// File: tb/tb_ir_sort_ctrl.sv
// tb_ir_sort_ctrl: randomized and directed bench for ir_sort_ctrl against a cycle-count reference model.
module tb_ir_sort_ctrl;
    localparam int SP = 10, VN = 3, HC = 50, PP = 20, PWC = 5, PWA = 2, PWB = 8;

    logic       clk = 1'b0, rst_n = 1'b0, servo_pwm, busy, sort_done;
    logic [1:0] iFlag = 2'b00, sort_class;
    logic [7:0] cnt_a, cnt_b;
    int         n_chk = 0, n_err = 0;

    // reference model: values the DUT must show during the current cycle
    int         mc, busy_left, m_class, m_cna, m_cnb, w;
    bit         m_pwm, m_done;
    logic [1:0] hist[$];

    ir_sort_ctrl #(.SAMPLE_PERIOD(SP), .VOTE_N(VN), .HOLD_CYCLES(HC), .PWM_PERIOD(PP),
                   .PW_CENTER(PWC), .PW_A(PWA), .PW_B(PWB)) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .iFlag(iFlag), .servo_pwm(servo_pwm), .busy(busy),
        .sort_class(sort_class), .sort_done(sort_done), .cnt_a(cnt_a), .cnt_b(cnt_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, mc);
        end
    endtask

    function automatic int exp_cnt(input int v);
`ifdef IR_SORT_COUNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic model_edge(input logic [1:0] f, input logic rn);
        int run;
        bit nxt_pwm;
        if (!rn) begin
            mc = 0; busy_left = 0; m_class = 0; m_cna = 0; m_cnb = 0;
            w = PWC; m_pwm = 0; m_done = 0; hist.delete();
            return;
        end
        nxt_pwm = (mc % PP) < w;
        if (mc % PP == PP - 1) w = (busy_left > HC) ? (m_class == 2 ? PWA : PWB) : PWC;
        m_done = busy_left == 1;
        if (busy_left > 0) busy_left--;
        else if (mc % SP == SP - 1) begin
            if (f == 2'b00 || f == 2'b11) hist.delete();
            else begin
                hist.push_back(f);
                run = 0;
                for (int i = hist.size() - 1; i >= 0 && hist[i] == f; i--) run++;
                if (run == VN) begin
                    busy_left = 2 * HC;
                    m_class = f;
                    if (f == 2'b10 && m_cna < 255) m_cna++;
                    if (f == 2'b01 && m_cnb < 255) m_cnb++;
                    hist.delete();
                end
            end
        end
        m_pwm = nxt_pwm;
        mc++;
    endtask

    task automatic step(input logic [1:0] f, input logic rn);
        @(negedge clk);
        check("busy", busy, busy_left > 0);
        check("sort_done", sort_done, m_done);
        check("sort_class", sort_class, m_class);
        check("servo_pwm", servo_pwm, m_pwm);
        check("cnt_a", cnt_a, exp_cnt(m_cna));
        check("cnt_b", cnt_b, exp_cnt(m_cnb));
        iFlag = f;
        rst_n = rn;
        model_edge(f, rn);
    endtask

    task automatic run(input logic [1:0] f, input int n);
        repeat (n) step(f, 1'b1);
    endtask

    task automatic reset_dut();
        step(2'b00, 1'b0);
        step(2'b00, 1'b0);
    endtask

    initial begin
        logic [1:0] f;
        model_edge(2'b00, 1'b0);
        reset_dut();
        run(2'b00, 200);
        reset_dut();
        run(2'b10, 31);
        check("busy_at_30", busy, 1);
        check("class_a", sort_class, 2'b10);
        run(2'b10, 100);
        reset_dut();
        run(2'b10, 20);
        run(2'b01, 30);
        run(2'b01, 1);
        check("class_b", sort_class, 2'b01);
        run(2'b00, 150);
        reset_dut();
        run(2'b10, 10);
        run(2'b11, 10);
        run(2'b10, 20);
        check("no_trig_after_invalid", busy, 0);
        run(2'b10, 20);
        reset_dut();
        run(2'b10, 60);
        step(2'b10, 1'b0);
        run(2'b00, 1);
        check("busy_after_rst", busy, 0);
        check("class_after_rst", sort_class, 2'b00);
        run(2'b00, 60);
        f = 2'b10;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 14) == 0) f = 2'($urandom_range(0, 3));
            step(f, $urandom_range(0, 599) != 0);
        end
        reset_dut();
        run(2'b10, 300 * 130 + 50);
        check("cnt_a_sat", cnt_a, exp_cnt(255));
        check("cnt_b_zero", cnt_b, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
